sweep_controller: RTL and testbench
===================================

# sweep_controller

Sweep engine between the user-configuration stage and the DDS phase-accumulator stage. It takes the configured base frequency, sweep range, sweep speed and sweep-mode switches. Every millisecond it produces the instantaneous output frequency, as a sawtooth-up, sawtooth-down or triangle sweep. With sweep off, it passes the base frequency straight through (registered).

## Interface

- `CLK_HZ`, default 100_000_000: system clock frequency; sets the 1 ms tick divider `TICK_DIV = CLK_HZ/1000`.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `freq_in`  in  20: base frequency in Hz, 1000..999999.
- `range_in`  in  17: sweep span in Hz, 0..50000.
- `speed_in`  in  13: step per ms in Hz, 0..4000.
- `mode_in`  in  2: 00 off, 01 saw-up, 10 saw-down, 11 triangle.
- `freq_cur`  out  20: instantaneous frequency to the DDS; reset 100000.
- `sweep_dir`  out  1: 1 = rising, 0 = falling; reset 1.
- `sweep_wrap`  out  1: one-cycle pulse at the end of each sweep period; reset 0.
- `sweep_active`  out  1: high when mode≠00, range≠0 and speed≠0; reset 0.

## Operation

- **Band registers**
  - `lo` = `freq_in`.
  - `hi` = min(`freq_in` + `range_in`, 999999), computed in 21 bits and then clamped.
  - Both are registered one cycle after the inputs. Reset values: `lo` = `hi` = 100000.
- **Change detect**
  - Registered copies of `freq_in`, `range_in` and `mode_in` are compared against the live inputs.
  - Any difference asserts `restart` for one cycle.
  - A change in `speed_in` never restarts; it takes effect at the next tick.
- **Restart**
  - `freq_cur` loads the start point: `lo` for modes 01 and 11, `hi` for mode 10.
  - `sweep_dir` loads 0 for mode 10 and 1 otherwise.
  - The tick counter is not reset.
- **State machine**, with states IDLE, UP, DOWN.
  - **IDLE:** entered when mode=00. `freq_cur` = `lo` every cycle and `sweep_active` = 0.
    - Mode 01 or 11 → UP.
    - Mode 10 → DOWN.
  - **UP, on tick:** let s = `freq_cur` + `speed_in` (21 bits).
    - s ≤ `hi`: `freq_cur` = s.
    - s > `hi`, saw-up: `freq_cur` = `lo` and pulse `sweep_wrap`.
    - s ≥ `hi`, triangle: `freq_cur` = `hi`, go to DOWN, `sweep_dir` = 0.
  - **DOWN, on tick:**
    - `freq_cur` ≥ `lo` + `speed_in`: subtract `speed_in`. In triangle mode, reaching exactly `lo` also counts as the end of the ramp (next bullet).
    - Otherwise, saw-down: `freq_cur` = `hi` and pulse `sweep_wrap`.
    - Otherwise, triangle: `freq_cur` = `lo`, go to UP, `sweep_dir` = 1, pulse `sweep_wrap`.
- **Degenerate cases**
  - `range_in` = 0 or `speed_in` = 0: `freq_cur` holds at the start point, and `sweep_wrap` never pulses.
  - `freq_cur` never leaves [`lo`, `hi`] and never exceeds 999999.

## Timing

- The tick is a single-cycle strobe, high when the divider counter equals TICK_DIV−1.
  - The counter wraps to 0 on that cycle.
  - The first tick comes TICK_DIV cycles after reset release.
- `freq_cur` and `sweep_wrap` update on the clock edge after the tick cycle: 1-cycle latency.
- Input to band registers: 1 cycle. Input change to `restart` to `freq_cur` reload: 2 cycles total.
- If a tick and a restart fall on the same cycle, restart wins: the tick is discarded and `sweep_wrap` stays 0.
- Mode change to 00: `freq_cur` = new `lo` two cycles later, and the state is IDLE.
- Asserting `rst_n` mid-sweep: all outputs go immediately to their reset values, the divider clears, and the state is IDLE.
- `sweep_wrap` is never high for two consecutive cycles.

## Structure

- Shared package `wavegen_pkg` holds:
  - constants `FREQ_MIN` = 1000, `FREQ_MAX` = 999999, `FREQ_DEFAULT` = 100000;
  - sweep-mode encodings `SWEEP_OFF`/`SAW_UP`/`SAW_DN`/`TRI`;
  - state encodings.
- One sub-module, `ms_tick_gen`: a parameterised `CLK_HZ` divider with a single-cycle `tick` output, reused by other millisecond-based blocks.
- The band clamp, change detection and FSM stay in the top level.

## Test plan

All scenarios use `CLK_HZ` = 4000, giving TICK_DIV = 4.

- **Reset:** `freq_cur` = 100000, `sweep_dir` = 1, `sweep_wrap` = 0, `sweep_active` = 0.
  - Hold mode 00 for 100 cycles → `freq_cur` stays 100000.
- **Saw-up:** `freq_in` = 100000, `range_in` = 3000, `speed_in` = 1000, mode 01.
  - `freq_cur` steps 100000 → 101000 → 102000 → 103000 → 100000, one step per tick.
  - `sweep_wrap` pulses once, on the return to 100000.
- **Triangle:** same band, mode 11.
  - Sequence is 100000, 101000, 102000, 103000 (`sweep_dir` goes 0), 102000, 101000, 100000, with a wrap pulse and `sweep_dir` = 1 at 100000.
- **Clamp:** `freq_in` = 998000, `range_in` = 5000, `speed_in` = 1000, mode 01.
  - `hi` = 999999 and `freq_cur` reaches 999000, then wraps to 998000 and never exceeds 999999.
- **Restart vs tick:** change `freq_in` to 200000 on a tick cycle mid-sweep.
  - No `sweep_wrap` pulse, and `freq_cur` = 200000 two cycles later.
  - Separately, changing `speed_in` alone causes no restart.
- **Degenerate and async reset:** `speed_in` = 0 in mode 11 → `freq_cur` frozen at `lo`, no wraps.
  - Then pulse `rst_n` low mid-cycle → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared constants and encodings for the waveform-generator datapath blocks.
package wavegen_pkg;

  localparam int unsigned FREQ_MIN     = 1000;
  localparam int unsigned FREQ_MAX     = 999999;
  localparam int unsigned FREQ_DEFAULT = 100000;

  typedef enum logic [1:0] {
    SWEEP_OFF = 2'b00,
    SAW_UP    = 2'b01,
    SAW_DN    = 2'b10,
    TRI       = 2'b11
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } sweep_state_e;

  // Upper band edge: base + span, saturated at the top of the DDS range.
  function automatic logic [19:0] band_hi(input logic [19:0] f, input logic [16:0] r);
    logic [20:0] sum;
    sum = {1'b0, f} + {4'b0, r};
    return (sum > 21'(FREQ_MAX)) ? 20'(FREQ_MAX) : sum[19:0];
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe: a single-cycle tick every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int          CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sweep_controller.sv
// Millisecond frequency sweep engine feeding the DDS stage: saw-up, saw-down
// or triangle sweeps over [lo, hi], or a registered pass-through of the base.
module sweep_controller
  import wavegen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] freq_in,
  input  logic [16:0] range_in,
  input  logic [12:0] speed_in,
  input  logic [1:0]  mode_in,
  output logic [19:0] freq_cur,
  output logic        sweep_dir,
  output logic        sweep_wrap,
  output logic        sweep_active
);

  logic         tick;
  logic [19:0]  lo;
  logic [19:0]  hi;
  logic [16:0]  range_q;
  sweep_mode_e  mode_q;
  logic         restart;

  sweep_state_e state;
  sweep_state_e state_n;
  logic [19:0]  freq_n;
  logic         dir_n;
  logic         wrap_n;
  logic [20:0]  sum_up;
  logic [20:0]  floor_dn;
  logic         can_step;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // lo doubles as the registered copy of freq_in for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo           <= 20'(FREQ_DEFAULT);
      hi           <= 20'(FREQ_DEFAULT);
      range_q      <= '0;
      mode_q       <= SWEEP_OFF;
      restart      <= 1'b0;
      sweep_active <= 1'b0;
    end else begin
      lo           <= freq_in;
      hi           <= band_hi(freq_in, range_in);
      range_q      <= range_in;
      mode_q       <= sweep_mode_e'(mode_in);
      restart      <= (freq_in != lo) || (range_in != range_q) || (mode_in != mode_q);
      sweep_active <= (mode_in != 2'b00) && (range_in != '0) && (speed_in != '0);
    end
  end

  assign sum_up   = {1'b0, freq_cur} + {8'b0, speed_in};
  assign floor_dn = {1'b0, lo} + {8'b0, speed_in};
  // An empty band or zero step freezes the sweep at its start point.
  assign can_step = tick && (speed_in != '0) && (hi > lo);

  // NOTE: every combinational output gets a default up front so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_n = state;
    freq_n  = freq_cur;
    dir_n   = sweep_dir;
    wrap_n  = 1'b0;
    if (restart) begin
      freq_n = (mode_q == SAW_DN) ? hi : lo;
      dir_n  = (mode_q != SAW_DN);
      unique case (mode_q)
        SWEEP_OFF: state_n = ST_IDLE;
        SAW_DN:    state_n = ST_DOWN;
        default:   state_n = ST_UP;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          freq_n = lo;
          if (mode_q == SAW_DN)         state_n = ST_DOWN;
          else if (mode_q != SWEEP_OFF) state_n = ST_UP;
        end
        ST_UP: if (can_step) begin
          if (mode_q == TRI && sum_up >= {1'b0, hi}) begin
            freq_n  = hi;
            state_n = ST_DOWN;
            dir_n   = 1'b0;
          end else if (sum_up > {1'b0, hi}) begin
            freq_n = lo;
            wrap_n = 1'b1;
          end else begin
            freq_n = sum_up[19:0];
          end
        end
        ST_DOWN: if (can_step) begin
          // Triangle treats landing exactly on lo as the bottom turn.
          if (mode_q == TRI && {1'b0, freq_cur} <= floor_dn) begin
            freq_n  = lo;
            state_n = ST_UP;
            dir_n   = 1'b1;
            wrap_n  = 1'b1;
          end else if ({1'b0, freq_cur} >= floor_dn) begin
            freq_n = freq_cur - {7'b0, speed_in};
          end else begin
            freq_n = hi;
            wrap_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      freq_cur   <= 20'(FREQ_DEFAULT);
      sweep_dir  <= 1'b1;
      sweep_wrap <= 1'b0;
    end else begin
      state      <= state_n;
      freq_cur   <= freq_n;
      sweep_dir  <= dir_n;
      sweep_wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: offset-based sweep model checked every cycle,
// directed literal scenarios, then randomized configuration changes.
module tb_sweep_controller;

  localparam int CLK_HZ = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] freq_in;
  logic [16:0] range_in;
  logic [12:0] speed_in;
  logic [1:0]  mode_in;
  logic [19:0] freq_cur;
  logic        sweep_dir;
  logic        sweep_wrap;
  logic        sweep_active;

  sweep_controller #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freq_in     (freq_in),
    .range_in    (range_in),
    .speed_in    (speed_in),
    .mode_in     (mode_in),
    .freq_cur    (freq_cur),
    .sweep_dir   (sweep_dir),
    .sweep_wrap  (sweep_wrap),
    .sweep_active(sweep_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned freq;
    int unsigned range;
    int unsigned mode;
  } cfg_t;

  typedef struct {
    cfg_t        p1;      // inputs seen at the previous edge
    cfg_t        p2;      // inputs seen two edges ago
    int unsigned freq;
    int unsigned n_edge;  // edges since reset release
    bit          dir;
    bit          wrap;
    bit          active;
  } model_t;

  model_t m;

  function automatic cfg_t cfg_default();
    cfg_t c;
    c.freq = 100000; c.range = 0; c.mode = 0;
    return c;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.p1 = cfg_default(); r.p2 = cfg_default();
    r.freq = 100000; r.n_edge = 0;
    r.dir = 1'b1; r.wrap = 1'b0; r.active = 1'b0;
    return r;
  endfunction

  // One clock edge. The sweep is a position 'off' inside the band [lo, hi].
  function automatic model_t step(input model_t s, input int unsigned f,
                                  input int unsigned rg, input int unsigned md,
                                  input int unsigned spd);
    model_t      r = s;
    int unsigned lo = s.p1.freq;
    int unsigned hi = s.p1.freq + s.p1.range;
    int unsigned span;
    int unsigned off;
    bit          changed;
    if (hi > 999999) hi = 999999;
    span    = hi - lo;
    off     = s.freq - lo;
    changed = (s.p1.freq != s.p2.freq) || (s.p1.range != s.p2.range) || (s.p1.mode != s.p2.mode);
    r.n_edge = s.n_edge + 1;
    r.wrap   = 1'b0;
    r.active = (md != 0) && (rg != 0) && (spd != 0);
    if (changed) begin
      r.freq = (s.p1.mode == 2) ? hi : lo;
      r.dir  = (s.p1.mode != 2);
    end else if (s.p1.mode == 0) begin
      r.freq = lo;
    end else if ((r.n_edge % 4 == 0) && spd != 0 && span > 0) begin
      case (s.p1.mode)
        1: if (off + spd > span) begin off = 0; r.wrap = 1'b1; end
           else off = off + spd;
        2: if (off >= spd) off = off - spd;
           else begin off = span; r.wrap = 1'b1; end
        default:
          if (s.dir) begin
            if (off + spd >= span) begin off = span; r.dir = 1'b0; end
            else off = off + spd;
          end else begin
            if (off <= spd) begin off = 0; r.dir = 1'b1; r.wrap = 1'b1; end
            else off = off - spd;
          end
      endcase
      r.freq = lo + off;
    end
    r.p2 = s.p1;
    r.p1.freq = f; r.p1.range = rg; r.p1.mode = md;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, 32'(freq_in), 32'(range_in), 32'(mode_in), 32'(speed_in));
  end

  always @(negedge clk) begin
    check("cyc_freq_cur",     32'(freq_cur),     m.freq);
    check("cyc_sweep_dir",    32'(sweep_dir),    32'(m.dir));
    check("cyc_sweep_wrap",   32'(sweep_wrap),   32'(m.wrap));
    check("cyc_sweep_active", 32'(sweep_active), 32'(m.active));
  end

  // ---------------- directed helpers ----------------
  int unsigned col_f[$];
  int unsigned col_d[$];
  int unsigned wrap_cnt;
  int unsigned wrap_f;
  int unsigned max_f;

  // Record each new freq_cur value (with its direction) until n_vals are seen.
  task automatic collect(input string name, input int n_vals);
    col_f.delete(); col_d.delete();
    wrap_cnt = 0; wrap_f = 0; max_f = 32'(freq_cur);
    col_f.push_back(32'(freq_cur));
    col_d.push_back(32'(sweep_dir));
    for (int c = 0; c < 300 && col_f.size() < n_vals; c++) begin
      @(negedge clk);
      if (sweep_wrap) begin wrap_cnt++; wrap_f = 32'(freq_cur); end
      if (32'(freq_cur) > max_f) max_f = 32'(freq_cur);
      if (32'(freq_cur) != col_f[col_f.size()-1]) begin
        col_f.push_back(32'(freq_cur));
        col_d.push_back(32'(sweep_dir));
      end
    end
    check({name, "_len"}, 32'(col_f.size()), 32'(n_vals));
    while (col_f.size() < n_vals) begin col_f.push_back(0); col_d.push_back(0); end
  endtask

  task automatic idle_at(input int unsigned f, input int unsigned rg, input int unsigned spd);
    mode_in = 2'b00; freq_in = 20'(f); range_in = 17'(rg); speed_in = 13'(spd);
    repeat (6) @(negedge clk);
  endtask

  int unsigned exp_saw[5] = '{100000, 101000, 102000, 103000, 100000};
  int unsigned exp_tri[7] = '{100000, 101000, 102000, 103000, 102000, 101000, 100000};
  int unsigned exp_clp[3] = '{998000, 999000, 998000};
  bit          found;
  int unsigned hold_f;
  int unsigned wraps;

  initial begin
    freq_in = 20'd100000; range_in = '0; speed_in = '0; mode_in = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_freq_cur", 32'(freq_cur), 100000);
    check("rst_sweep_dir", 32'(sweep_dir), 1);
    check("rst_sweep_wrap", 32'(sweep_wrap), 0);
    check("rst_sweep_active", 32'(sweep_active), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_hold_freq", 32'(freq_cur), 100000);

    // Saw-up over 100000..103000 in 1000 Hz steps
    range_in = 17'd3000; speed_in = 13'd1000; mode_in = 2'b01;
    collect("saw", 5);
    for (int i = 0; i < 5; i++) check($sformatf("saw_val%0d", i), col_f[i], exp_saw[i]);
    check("saw_wrap_cnt", wrap_cnt, 1);
    check("saw_wrap_at", wrap_f, 100000);

    // Triangle over the same band
    idle_at(100000, 3000, 1000);
    mode_in = 2'b11;
    collect("tri", 7);
    for (int i = 0; i < 7; i++) check($sformatf("tri_val%0d", i), col_f[i], exp_tri[i]);
    check("tri_dir_at_top", col_d[3], 0);
    check("tri_dir_at_end", col_d[6], 1);
    check("tri_wrap_cnt", wrap_cnt, 1);
    check("tri_wrap_at", wrap_f, 100000);

    // Band clamped at 999999
    idle_at(998000, 5000, 1000);
    mode_in = 2'b01;
    collect("clamp", 3);
    for (int i = 0; i < 3; i++) check($sformatf("clamp_val%0d", i), col_f[i], exp_clp[i]);
    check("clamp_wrap_cnt", wrap_cnt, 1);
    check("clamp_not_above_max", 32'(max_f <= 999999), 1);

    // Base change landing on a tick cycle mid-sweep
    idle_at(100000, 3000, 1000);
    mode_in = 2'b01;
    repeat (10) @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (((m.n_edge + 1) % 4 == 0) && freq_cur != 20'd103000) found = 1'b1;
    end
    check("rt_tick_found", 32'(found), 1);
    freq_in = 20'd200000;
    wraps = 0;
    repeat (2) begin @(negedge clk); if (sweep_wrap) wraps++; end
    check("rt_no_wrap", wraps, 0);
    check("rt_reload", 32'(freq_cur), 200000);

    // Speed change alone keeps the sweep position
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if ((m.n_edge % 4 == 0) && freq_cur != 20'd200000) found = 1'b1;
    end
    check("spd_tick_found", 32'(found), 1);
    hold_f = 32'(freq_cur);
    speed_in = 13'd500;
    repeat (2) @(negedge clk);
    check("spd_no_restart", 32'(freq_cur), hold_f);

    // Zero speed freezes the triangle at lo
    idle_at(300000, 2000, 0);
    mode_in = 2'b11;
    repeat (3) @(negedge clk);
    wraps = 0;
    repeat (40) begin @(negedge clk); if (sweep_wrap) wraps++; end
    check("deg_frozen", 32'(freq_cur), 300000);
    check("deg_no_wrap", wraps, 0);
    check("deg_inactive", 32'(sweep_active), 0);

    // Asynchronous reset mid-sweep, then first tick after release
    speed_in = 13'd1000;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_freq_cur", 32'(freq_cur), 100000);
    check("arst_sweep_dir", 32'(sweep_dir), 1);
    check("arst_sweep_wrap", 32'(sweep_wrap), 0);
    check("arst_sweep_active", 32'(sweep_active), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_reload", 32'(freq_cur), 300000);
    @(negedge clk);
    check("arst_first_tick", 32'(freq_cur), 301000);

    // Randomized configuration changes
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 9) < 2) begin
        speed_in = 13'($urandom_range(0, 4000));
      end else begin
        freq_in  = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(990000, 999999))
                                                : 20'($urandom_range(1000, 999999));
        case ($urandom_range(0, 9))
          0:       range_in = '0;
          1, 2:    range_in = 17'($urandom_range(1000, 50000));
          default: range_in = 17'($urandom_range(1, 5000));
        endcase
        speed_in = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 4000));
        mode_in  = 2'($urandom_range(0, 3));
      end
      repeat ($urandom_range(1, 80)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
